// File: rtl/pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// pwm_multi_ch
// Multi-channel PWM peripheral on the tinyriscv peripheral bus. Every channel
// has its own PERIOD/DUTY shadow registers, a CTRL register and a STAT flag.
// PERIOD/DUTY are double-buffered: the counter works from active copies that
// only pick up new shadow values at a period boundary (or while disabled), so
// a bus write can never produce a truncated or stretched pulse.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   we_i        write strobe, one cycle per write
//   write_addr  write address, [7:4] channel, [3:2] register
//   write_data  write data
//   read_addr   read address, [7:4] channel, [3:2] register
//   read_data   combinational register readback, zero-extended
//   pwm_o       registered PWM outputs, one bit per channel
//   irq_o       OR over channels of (FLAG & CTRL.IE)
//
// Register map per channel (offset = ch*16 + reg*4)
//   0 PERIOD  1 DUTY  2 CTRL {IE,INV,CTR,EN}  3 STAT {FLAG}, write 1 clears
// -----------------------------------------------------------------------------
module pwm_multi_ch #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [31:0]       write_addr,
  input  logic [31:0]       write_data,
  input  logic [31:0]       read_addr,
  output logic [31:0]       read_data,
  output logic [CH_NUM-1:0] pwm_o,
  output logic              irq_o
);

  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_DUTY   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STAT   = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CTR = 1;
  localparam int CTRL_INV = 2;
  localparam int CTRL_IE  = 3;

  logic [3:0]        w_wr_ch;
  logic [1:0]        w_wr_reg;
  logic [3:0]        w_rd_ch;
  logic [1:0]        w_rd_reg;
  logic [31:0]       w_rd_word [CH_NUM];
  logic [CH_NUM-1:0] w_irq;
  logic              w_unused;

  assign w_wr_ch  = write_addr[7:4];
  assign w_wr_reg = write_addr[3:2];
  assign w_rd_ch  = read_addr[7:4];
  assign w_rd_reg = read_addr[3:2];

  // Only the low address byte and the low data bits are meaningful.
  assign w_unused = ^{write_addr, read_addr, write_data};

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    logic             w_wr_sel;
    logic [3:0]       w_ctrl_nxt;
    logic             w_reload;
    logic             w_raw;
    logic [31:0]      w_rd_val;

    logic [CNT_W-1:0] r_period_sh;
    logic [CNT_W-1:0] r_duty_sh;
    logic [CNT_W-1:0] r_period_a;
    logic [CNT_W-1:0] r_duty_a;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_ctrl;
    logic             r_ctr_a;   // counting mode in force for the current period
    logic             r_dir;     // 0 = up, 1 = down (center mode only)
    logic             r_flag;
    logic             r_pwm;

    // Channels at or beyond CH_NUM have no generate instance, so writes to
    // them match nothing and are dropped.
    assign w_wr_sel   = we_i && (w_wr_ch == 4'(g));
    assign w_ctrl_nxt = (w_wr_sel && (w_wr_reg == REG_CTRL)) ? write_data[3:0] : r_ctrl;

    // Period boundary: edge mode at the top of the ramp, center mode at the
    // bottom of the down-slope.
    assign w_reload = r_ctr_a ? (r_dir && (r_cnt == '0)) : (r_cnt == r_period_a);
    assign w_raw    = r_ctrl[CTRL_EN] && (r_cnt < r_duty_a);

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
      // NOTE: every register is a plain flop, not a memory array, so all of
      // them can be cleared by reset without blocking RAM inference.
      if (rst) begin
        r_period_sh <= '0;
        r_duty_sh   <= '0;
        r_period_a  <= '0;
        r_duty_a    <= '0;
        r_cnt       <= '0;
        r_ctrl      <= '0;
        r_ctr_a     <= 1'b0;
        r_dir       <= 1'b0;
        r_flag      <= 1'b0;
        r_pwm       <= 1'b0;
      end else begin
        if (w_wr_sel && (w_wr_reg == REG_PERIOD)) r_period_sh <= write_data[CNT_W-1:0];
        if (w_wr_sel && (w_wr_reg == REG_DUTY))   r_duty_sh   <= write_data[CNT_W-1:0];
        r_ctrl <= w_ctrl_nxt;

        // A period end in the same cycle as a write-1-clear keeps the flag set.
        if (r_ctrl[CTRL_EN] && w_reload)
          r_flag <= 1'b1;
        else if (w_wr_sel && (w_wr_reg == REG_STAT) && write_data[0])
          r_flag <= 1'b0;

        r_pwm <= w_raw ^ r_ctrl[CTRL_INV];

        if (!r_ctrl[CTRL_EN]) begin
          // Idle: track the shadows so enabling starts with fresh values.
          // The incoming CTRL value is used so EN and CTR written together
          // start in the requested mode.
          r_cnt      <= '0;
          r_dir      <= 1'b0;
          r_period_a <= r_period_sh;
          r_duty_a   <= r_duty_sh;
          r_ctr_a    <= w_ctrl_nxt[CTRL_CTR];
        end else if (w_reload) begin
          // Reading the shadow here picks up its pre-edge value, so a PERIOD
          // write landing on the reload cycle only applies one period later.
          r_period_a <= r_period_sh;
          r_duty_a   <= r_duty_sh;
          r_ctr_a    <= r_ctrl[CTRL_CTR];
          r_dir      <= 1'b0;
          // Center mode spends the cnt=0 slot on this reload cycle, so the
          // next up-slope starts at 1 (or stays at 0 for a zero period).
          r_cnt      <= (r_ctr_a && r_ctrl[CTRL_CTR] && (r_period_sh != '0)) ? CNT_W'(1) : '0;
        end else if (r_ctr_a) begin
          if (!r_dir && (r_cnt == r_period_a)) begin
            r_dir <= 1'b1;
            r_cnt <= (r_period_a == '0) ? '0 : r_period_a - CNT_W'(1);
          end else if (r_dir) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    // NOTE: a default assignment ahead of the case keeps this block purely
    // combinational, with no inferred latch.
    always_comb begin
      w_rd_val = '0;
      case (w_rd_reg)
        REG_PERIOD: w_rd_val = 32'(r_period_sh);
        REG_DUTY:   w_rd_val = 32'(r_duty_sh);
        REG_CTRL:   w_rd_val = 32'(r_ctrl);
        REG_STAT:   w_rd_val = 32'(r_flag);
      endcase
    end

    assign w_rd_word[g] = (w_rd_ch == 4'(g)) ? w_rd_val : '0;
    assign w_irq[g]     = r_flag & r_ctrl[CTRL_IE];
    assign pwm_o[g]     = r_pwm;
  end

  // At most one channel word is non-zero; an unmatched channel reads 0.
  always_comb begin
    read_data = '0;
    for (int c = 0; c < CH_NUM; c++) read_data = read_data | w_rd_word[c];
  end

  assign irq_o = |w_irq;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_ch
// Directed self-checking bench for pwm_multi_ch (CH_NUM=4, CNT_W=16).
// Inputs are driven on the falling edge, outputs sampled on the falling edge
// (reads 1 ns later), so nothing is sampled at the active edge.
// -----------------------------------------------------------------------------
module tb_pwm_multi_ch;

  localparam int CH_NUM = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              we_i;
  logic [31:0]       write_addr;
  logic [31:0]       write_data;
  logic [31:0]       read_addr;
  logic [31:0]       read_data;
  logic [CH_NUM-1:0] pwm_o;
  logic              irq_o;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int unsigned cyc          = 0;

  pwm_multi_ch #(.CH_NUM(CH_NUM), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we_i),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .pwm_o      (pwm_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a falling edge; returns at the next falling edge with the
  // write already registered.
  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    we_i       = 1'b1;
    write_addr = {24'h0, addr};
    write_data = data;
    @(negedge clk);
    we_i       = 1'b0;
    write_addr = '0;
    write_data = '0;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data);
    read_addr = {24'h0, addr};
    #1;
    data = read_data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sample_pwm(input int ch, input int n, output logic [63:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v[i] = pwm_o[ch];
    end
  endtask

  task automatic wait_flag(input logic [7:0] addr, input int budget, output bit found);
    logic [31:0] d;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      rd(addr, d);
      if (d[0]) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; we_i = 1'b0; write_addr = '0; write_data = '0; read_addr = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (pwm_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_pwm: got %b expected 0000", pwm_o); end
    tests_run++;
    if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    rd(8'h08, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_ctrl0: got %h expected 0", d); end
    rd(8'h3C, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_stat3: got %h expected 0", d); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // PERIOD=9 DUTY=3 edge mode: 3 high, 7 low, flag every 10 clocks.
  task automatic test_edge();
    logic [63:0] got, exp;
    logic [31:0] d;
    bit          found;
    int unsigned t1, t2;
    do_reset();
    wr(8'h00, 9); wr(8'h04, 3); wr(8'h08, 32'h1);
    sample_pwm(0, 30, got);
    exp = '0;
    for (int k = 1; k <= 30; k++) exp[k-1] = (((k - 1) % 10) < 3);
    tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL edge_wave: got %h expected %h", got, exp); end
    rd(8'h0C, d);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL edge_flag: got %h expected 1", d); end
    tests_run++;
    if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL edge_irq_masked: got %b expected 0", irq_o); end
    wr(8'h0C, 1);
    wait_flag(8'h0C, 30, found);
    t1 = cyc;
    wr(8'h0C, 1);
    wait_flag(8'h0C, 30, found);
    t2 = cyc;
    tests_run++;
    if (!found || (t2 - t1) != 10) begin
      tests_failed++; $display("FAIL edge_flag_period: got %0d (found=%0d) expected 10", t2 - t1, found);
    end
  endtask

  // Center mode: cnt 0..9..1, period 18; cnt<3 holds for 0,1,2 on the way up
  // and 2,1 on the way down, a 5-clock pulse centred on cnt=0.
  task automatic test_center();
    logic [63:0] got, exp;
    logic [31:0] d;
    bit          found, irq_seen;
    int unsigned t1, t2;
    int          m, c;
    do_reset();
    wr(8'h00, 9); wr(8'h04, 3); wr(8'h08, 32'h3);
    got = '0; irq_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      got[i] = pwm_o[0];
      if (irq_o) irq_seen = 1'b1;
    end
    exp = '0;
    for (int k = 1; k <= 40; k++) begin
      m = (k - 1) % 18;
      c = (m <= 9) ? m : 18 - m;
      exp[k-1] = (c < 3);
    end
    tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL center_wave: got %h expected %h", got, exp); end
    rd(8'h0C, d);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL center_flag: got %h expected 1", d); end
    tests_run++;
    if (irq_seen !== 1'b0) begin tests_failed++; $display("FAIL center_irq_masked: got %b expected 0", irq_seen); end
    wr(8'h0C, 1);
    wait_flag(8'h0C, 40, found);
    t1 = cyc;
    wr(8'h0C, 1);
    wait_flag(8'h0C, 40, found);
    t2 = cyc;
    tests_run++;
    if (!found || (t2 - t1) != 18) begin
      tests_failed++; $display("FAIL center_flag_period: got %0d (found=%0d) expected 18", t2 - t1, found);
    end
    wr(8'h08, 32'hB);
    tests_run++;
    if (irq_o !== 1'b1) begin tests_failed++; $display("FAIL center_irq_enabled: got %b expected 1", irq_o); end
  endtask

  // DUTY written while cnt=1: current period keeps 3, next period 7.
  task automatic test_mid_duty();
    logic [63:0] got, exp;
    int          ph, dv;
    do_reset();
    wr(8'h00, 9); wr(8'h04, 3); wr(8'h08, 32'h1);
    wr(8'h04, 7);
    sample_pwm(0, 20, got);
    exp = '0;
    for (int k = 2; k <= 21; k++) begin
      ph = (k - 1) % 10;
      dv = ((k - 1) < 10) ? 3 : 7;
      exp[k-2] = (ph < dv);
    end
    tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL mid_duty_wave: got %h expected %h", got, exp); end
  endtask

  task automatic test_duty_limits();
    logic [63:0] got;
    do_reset();
    wr(8'h00, 9); wr(8'h04, 0); wr(8'h08, 32'h1);
    sample_pwm(0, 12, got);
    tests_run++;
    if (got[11:0] !== 12'h000) begin tests_failed++; $display("FAIL duty0_low: got %h expected 000", got[11:0]); end
    wr(8'h08, 32'h5);
    sample_pwm(0, 12, got);
    tests_run++;
    if (got[11:0] !== 12'hFFF) begin tests_failed++; $display("FAIL duty0_inv_high: got %h expected fff", got[11:0]); end
    wr(8'h04, 12); wr(8'h08, 32'h1);
    repeat (12) @(negedge clk);
    sample_pwm(0, 20, got);
    tests_run++;
    if (got[19:0] !== 20'hFFFFF) begin tests_failed++; $display("FAIL duty_gt_period_high: got %h expected fffff", got[19:0]); end
    wr(8'h08, 32'h5);
    sample_pwm(0, 12, got);
    tests_run++;
    if (got[11:0] !== 12'h000) begin tests_failed++; $display("FAIL duty_gt_period_inv_low: got %h expected 000", got[11:0]); end
    wr(8'h08, 32'h4);
    @(negedge clk);
    sample_pwm(0, 12, got);
    tests_run++;
    if (got[11:0] !== 12'hFFF) begin tests_failed++; $display("FAIL disabled_inv_idle: got %h expected fff", got[11:0]); end
    wr(8'h18, 32'h4);
    @(negedge clk);
    tests_run++;
    if (pwm_o[1] !== 1'b1) begin tests_failed++; $display("FAIL ch1_disabled_inv_idle: got %b expected 1", pwm_o[1]); end
  endtask

  // STAT write-1 landing on the wrap edge: set wins.
  task automatic test_flag_clear_race();
    logic [31:0] d;
    bit          found;
    do_reset();
    wr(8'h00, 9); wr(8'h04, 3); wr(8'h08, 32'h9);
    wait_flag(8'h0C, 30, found);
    tests_run++;
    if (!found || irq_o !== 1'b1) begin tests_failed++; $display("FAIL race_first_flag: got found=%0d irq=%b expected 1/1", found, irq_o); end
    repeat (9) @(negedge clk);
    wr(8'h0C, 1);
    rd(8'h0C, d);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL race_set_wins: got %h expected 1", d); end
    tests_run++;
    if (irq_o !== 1'b1) begin tests_failed++; $display("FAIL race_irq_held: got %b expected 1", irq_o); end
    @(negedge clk);
    wr(8'h0C, 1);
    tests_run++;
    if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL race_clear: got %b expected 0", irq_o); end
  endtask

  task automatic test_addressing();
    logic [31:0] d;
    do_reset();
    wr(8'h00, 32'h1234);
    wr(8'h40, 32'hFFFF); wr(8'h48, 32'hF); wr(8'h4C, 32'h1);
    rd(8'h40, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL bad_ch_period: got %h expected 0", d); end
    rd(8'h48, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL bad_ch_ctrl: got %h expected 0", d); end
    rd(8'h00, d);
    tests_run++;
    if (d !== 32'h1234) begin tests_failed++; $display("FAIL bad_ch_no_alias: got %h expected 1234", d); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (pwm_o !== 4'b0000 || irq_o !== 1'b0) begin tests_failed++; $display("FAIL bad_ch_outputs: got %b/%b expected 0000/0", pwm_o, irq_o); end
    wr(8'h14, 32'h000ABCDE);
    rd(8'h14, d);
    tests_run++;
    if (d !== 32'h0000BCDE) begin tests_failed++; $display("FAIL truncate_period: got %h expected 0000bcde", d); end
    wr(8'h28, 32'hFF);
    rd(8'h28, d);
    tests_run++;
    if (d !== 32'hF) begin tests_failed++; $display("FAIL ctrl_width: got %h expected f", d); end
    wr(8'h07, 32'h55);
    rd(8'h06, d);
    tests_run++;
    if (d !== 32'h55) begin tests_failed++; $display("FAIL low_addr_bits: got %h expected 55", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    wr(8'h00, 9); wr(8'h04, 3); wr(8'h08, 32'hD);
    wr(8'h18, 32'h4);
    repeat (14) @(negedge clk);
    tests_run++;
    if (pwm_o[1] !== 1'b1 || irq_o !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_state: got %b/%b expected 1/1", pwm_o[1], irq_o); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (pwm_o !== 4'b0000) begin tests_failed++; $display("FAIL mid_reset_pwm: got %b expected 0000", pwm_o); end
    tests_run++;
    if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_irq: got %b expected 0", irq_o); end
    rd(8'h00, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL mid_reset_period: got %h expected 0", d); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (pwm_o !== 4'b0000) begin tests_failed++; $display("FAIL post_reset_idle: got %b expected 0000", pwm_o); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_mid_duty();
    test_duty_limits();
    test_flag_clear_race();
    test_addressing();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
